// File: rtl/riscv_pkg.sv
// Shared pipeline types for the hazard controller: stage records, forward selects
// and controller FSM states.
package riscv_pkg;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       wen;
        logic       load;
    } stage_rec_t;

    localparam stage_rec_t REC_BUBBLE = '0;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StLuStall = 2'b01,
        StMemWait = 2'b10
    } hc_state_t;

    // A load sitting in MEM has no result yet, so it can only be forwarded from WB.
    function automatic fwd_sel_t fwd_pick(input logic mem_hit, input logic mem_load,
                                          input logic wb_hit);
        fwd_sel_t sel;
        sel = FWD_RF;
        if (mem_hit && !mem_load) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side attributes in, pipeline enables / flushes / forward selects out.
interface hazard_ctrl_if;
    import riscv_pkg::*;

    logic        id_valid;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic [4:0]  id_rd_addr;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic        id_rd_wen;
    logic        id_is_load;
    logic        ex_br_taken;
    logic        mem_ready;

    logic        pc_en;
    logic        if_id_en;
    logic        if_id_flush;
    logic        id_ex_flush;
    fwd_sel_t    fwd_a_sel;
    fwd_sel_t    fwd_b_sel;
    logic [31:0] stall_cnt;

    modport master (
        output id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr,
        output id_uses_rs1, id_uses_rs2, id_rd_wen, id_is_load,
        output ex_br_taken, mem_ready,
        input  pc_en, if_id_en, if_id_flush, id_ex_flush,
        input  fwd_a_sel, fwd_b_sel, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr,
        input  id_uses_rs1, id_uses_rs2, id_rd_wen, id_is_load,
        input  ex_br_taken, mem_ready,
        output pc_en, if_id_en, if_id_flush, id_ex_flush,
        output fwd_a_sel, fwd_b_sel, stall_cnt
    );

endinterface

// File: rtl/hazard_match.sv
// Compares one stage record's destination against two source addresses.
module hazard_match
    import riscv_pkg::*;
(
    input  stage_rec_t rec_i,
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    output logic       match_rs1_o,
    output logic       match_rs2_o
);

    logic writer;
    logic unused_rec;

    // x0 is hard-wired to zero, so a write to it never produces a dependency.
    assign writer      = rec_i.valid & rec_i.wen & (rec_i.rd != REG_X0);
    assign match_rs1_o = writer & (rec_i.rd == rs1_i);
    assign match_rs2_o = writer & (rec_i.rd == rs2_i);

    assign unused_rec  = ^{rec_i.rs1, rec_i.rs2, rec_i.load};

endmodule

// File: rtl/hazard_ctrl.sv
// In-order pipeline hazard controller: load-use stall, branch flush, memory-wait freeze
// and EX operand forwarding selects.
module hazard_ctrl
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave bus
);

    stage_rec_t  ex_q, ex_d;
    stage_rec_t  mem_q, mem_d;
    stage_rec_t  wb_q, wb_d;
    stage_rec_t  id_rec;
    hc_state_t   state_q, state_d;
    hc_state_t   ret_q, ret_d;
    hc_state_t   eff_state;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic        ex_hit_rs1, ex_hit_rs2;
    logic        mem_hit_rs1, mem_hit_rs2;
    logic        wb_hit_rs1, wb_hit_rs2;
    logic        load_use;
    logic        lu_stall;
    logic        pc_en, if_id_en, if_id_flush, id_ex_flush;
    fwd_sel_t    fwd_a, fwd_b;

    assign id_rec = '{
        valid: 1'b1,
        rs1:   bus.id_rs1_addr,
        rs2:   bus.id_rs2_addr,
        rd:    bus.id_rd_addr,
        wen:   bus.id_rd_wen,
        load:  bus.id_is_load
    };

    hazard_match u_match_ex (
        .rec_i       (ex_q),
        .rs1_i       (bus.id_rs1_addr),
        .rs2_i       (bus.id_rs2_addr),
        .match_rs1_o (ex_hit_rs1),
        .match_rs2_o (ex_hit_rs2)
    );

    hazard_match u_match_mem (
        .rec_i       (mem_q),
        .rs1_i       (ex_q.rs1),
        .rs2_i       (ex_q.rs2),
        .match_rs1_o (mem_hit_rs1),
        .match_rs2_o (mem_hit_rs2)
    );

    hazard_match u_match_wb (
        .rec_i       (wb_q),
        .rs1_i       (ex_q.rs1),
        .rs2_i       (ex_q.rs2),
        .match_rs1_o (wb_hit_rs1),
        .match_rs2_o (wb_hit_rs2)
    );

    assign load_use = bus.id_valid & ex_q.load &
                      ((bus.id_uses_rs1 & ex_hit_rs1) | (bus.id_uses_rs2 & ex_hit_rs2));

    // While waiting on memory, behave as the state that was interrupted once it resumes.
    assign eff_state = (state_q == StMemWait) ? ret_q : state_q;

    assign lu_stall = load_use & bus.mem_ready & ~bus.ex_br_taken & (eff_state == StRun);

    always_comb begin
        ex_d        = ex_q;
        mem_d       = mem_q;
        wb_d        = wb_q;
        state_d     = state_q;
        ret_d       = ret_q;
        stall_cnt_d = stall_cnt_q;
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        fwd_a       = fwd_pick(mem_hit_rs1, mem_q.load, wb_hit_rs1);
        fwd_b       = fwd_pick(mem_hit_rs2, mem_q.load, wb_hit_rs2);

        if (!bus.mem_ready) begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            if (state_q != StMemWait) begin
                state_d = StMemWait;
                ret_d   = state_q;
            end
        end else begin
            if (bus.ex_br_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (lu_stall) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
                stall_cnt_d = stall_cnt_q + 32'd1;
            end

            state_d = lu_stall ? StLuStall : StRun;
            ret_d   = StRun;
            wb_d    = mem_q;
            mem_d   = ex_q;
            ex_d    = (id_ex_flush || !bus.id_valid) ? REC_BUBBLE : id_rec;
        end

        if (rst) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            if_id_flush = 1'b0;
            id_ex_flush = 1'b0;
            fwd_a       = FWD_RF;
            fwd_b       = FWD_RF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= REC_BUBBLE;
            mem_q       <= REC_BUBBLE;
            wb_q        <= REC_BUBBLE;
            state_q     <= StRun;
            ret_q       <= StRun;
            stall_cnt_q <= 32'd0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            state_q     <= state_d;
            ret_q       <= ret_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.pc_en       = pc_en;
    assign bus.if_id_en    = if_id_en;
    assign bus.if_id_flush = if_id_flush;
    assign bus.id_ex_flush = id_ex_flush;
    assign bus.fwd_a_sel   = fwd_a;
    assign bus.fwd_b_sel   = fwd_b;
    assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed hazard scenarios followed by random traffic,
// checked against an in-flight instruction queue model.
module tb_hazard_ctrl;
    import riscv_pkg::*;

    typedef struct {
        bit       rst;
        bit       valid;
        bit [4:0] rs1;
        bit [4:0] rs2;
        bit [4:0] rd;
        bit       u1;
        bit       u2;
        bit       wen;
        bit       load;
        bit       br;
        bit       mr;
    } stim_t;

    typedef struct {
        bit       valid;
        bit [4:0] rs1;
        bit [4:0] rs2;
        bit [4:0] rd;
        bit       wen;
        bit       load;
    } ifl_t;

    typedef struct {
        string     tag;
        bit        pc_en;
        bit        if_id_en;
        bit        if_id_flush;
        bit        id_ex_flush;
        bit [1:0]  fa;
        bit [1:0]  fb;
        bit [31:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hazard_ctrl_if bus ();

    hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t      exp_q[$];
    ifl_t      pipe[$];   // in-flight instructions, [0] = EX, [1] = MEM, [2] = WB
    bit [31:0] m_cnt;
    int        n_tests = 0;
    int        n_fail  = 0;
    ifl_t      bubble  = '{default: 0};

    function automatic bit writes(ifl_t p, bit [4:0] r);
        return p.valid && p.wen && (p.rd != 5'd0) && (p.rd == r);
    endfunction

    function automatic bit [1:0] fwd_of(bit [4:0] r);
        if (writes(pipe[1], r) && !pipe[1].load) return 2'b01;
        if (writes(pipe[2], r)) return 2'b10;
        return 2'b00;
    endfunction

    function automatic stim_t ins(bit [4:0] rs1, bit [4:0] rs2, bit [4:0] rd,
                                  bit u1, bit u2, bit wen, bit load);
        stim_t s;
        s = '{default: 0};
        s.valid = 1'b1;
        s.rs1   = rs1;
        s.rs2   = rs2;
        s.rd    = rd;
        s.u1    = u1;
        s.u2    = u2;
        s.wen   = wen;
        s.load  = load;
        s.mr    = 1'b1;
        return s;
    endfunction

    function automatic stim_t nop();
        stim_t s;
        s = '{default: 0};
        s.mr = 1'b1;
        return s;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, predict the DUT response, then advance the model.
    task automatic step(input stim_t s, input string tag);
        exp_t e;
        ifl_t nw;
        bit   lu;
        @(posedge clk);
        #1;
        rst             = s.rst;
        bus.id_valid    = s.valid;
        bus.id_rs1_addr = s.rs1;
        bus.id_rs2_addr = s.rs2;
        bus.id_rd_addr  = s.rd;
        bus.id_uses_rs1 = s.u1;
        bus.id_uses_rs2 = s.u2;
        bus.id_rd_wen   = s.wen;
        bus.id_is_load  = s.load;
        bus.ex_br_taken = s.br;
        bus.mem_ready   = s.mr;

        lu = s.valid && pipe[0].load &&
             ((s.u1 && writes(pipe[0], s.rs1)) || (s.u2 && writes(pipe[0], s.rs2)));

        e.tag = tag;
        e.cnt = m_cnt;
        if (s.rst) begin
            e.pc_en = 0; e.if_id_en = 0; e.if_id_flush = 0; e.id_ex_flush = 0;
            e.fa = 2'b00; e.fb = 2'b00;
        end else begin
            e.fa = fwd_of(pipe[0].rs1);
            e.fb = fwd_of(pipe[0].rs2);
            if (!s.mr) begin
                e.pc_en = 0; e.if_id_en = 0; e.if_id_flush = 0; e.id_ex_flush = 0;
            end else if (s.br) begin
                e.pc_en = 1; e.if_id_en = 1; e.if_id_flush = 1; e.id_ex_flush = 1;
            end else if (lu) begin
                e.pc_en = 0; e.if_id_en = 0; e.if_id_flush = 0; e.id_ex_flush = 1;
            end else begin
                e.pc_en = 1; e.if_id_en = 1; e.if_id_flush = 0; e.id_ex_flush = 0;
            end
        end
        exp_q.push_back(e);

        if (s.rst) begin
            pipe  = '{bubble, bubble, bubble};
            m_cnt = 32'd0;
        end else if (s.mr) begin
            if (!s.br && lu) m_cnt = m_cnt + 32'd1;
            nw = bubble;
            if (s.valid && !s.br && !lu) begin
                nw = '{valid: 1'b1, rs1: s.rs1, rs2: s.rs2, rd: s.rd, wen: s.wen, load: s.load};
            end
            pipe.push_front(nw);
            void'(pipe.pop_back());
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check({e.tag, ".pc_en"},       32'(bus.pc_en),       32'(e.pc_en));
                check({e.tag, ".if_id_en"},    32'(bus.if_id_en),    32'(e.if_id_en));
                check({e.tag, ".if_id_flush"}, 32'(bus.if_id_flush), 32'(e.if_id_flush));
                check({e.tag, ".id_ex_flush"}, 32'(bus.id_ex_flush), 32'(e.id_ex_flush));
                check({e.tag, ".fwd_a"},       32'(bus.fwd_a_sel),   32'(e.fa));
                check({e.tag, ".fwd_b"},       32'(bus.fwd_b_sel),   32'(e.fb));
                check({e.tag, ".stall_cnt"},   bus.stall_cnt,        e.cnt);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        stim_t s;
        pipe  = '{bubble, bubble, bubble};
        m_cnt = 32'd0;
        bus.id_valid = 0; bus.id_rs1_addr = 0; bus.id_rs2_addr = 0; bus.id_rd_addr = 0;
        bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0; bus.id_rd_wen = 0; bus.id_is_load = 0;
        bus.ex_br_taken = 0; bus.mem_ready = 1;
        repeat (2) @(posedge clk);

        s = nop(); s.rst = 1;
        step(s, "in_reset");
        step(nop(), "post_reset");

        // lw x5 ; add x6,x5,x1
        step(ins(2, 0, 5, 1, 0, 1, 1), "lu_lw");
        step(ins(5, 1, 6, 1, 1, 1, 0), "lu_stall");
        step(ins(5, 1, 6, 1, 1, 1, 0), "lu_reissue");
        step(nop(), "lu_fwd_wb");
        step(nop(), "lu_drain");

        // add x3 ; sub x4,x3,x3
        step(ins(1, 2, 3, 1, 1, 1, 0), "exmem_add");
        step(ins(3, 3, 4, 1, 1, 1, 0), "exmem_sub");
        step(nop(), "exmem_fwd");

        // write x0 then read x0; load to x0 then LUI x7
        step(ins(1, 2, 0, 1, 1, 1, 0), "x0_write");
        step(ins(0, 0, 8, 1, 1, 1, 0), "x0_read");
        step(nop(), "x0_fwd");
        step(ins(1, 0, 0, 1, 0, 1, 1), "x0_lw");
        step(ins(0, 0, 7, 1, 0, 1, 0), "lui_x7");
        step(nop(), "lui_after");

        // x9 in MEM and WB together
        step(ins(1, 0, 9, 1, 0, 1, 0), "prio_w1");
        step(ins(2, 0, 9, 1, 0, 1, 0), "prio_w2");
        step(ins(9, 9, 10, 1, 1, 1, 0), "prio_rd");
        step(nop(), "prio_fwd");

        // load x9 in MEM is not forwarded; reaches WB after the stall
        step(ins(1, 0, 9, 1, 0, 1, 1), "ldm_lw");
        step(ins(9, 9, 11, 0, 0, 1, 0), "ldm_nouse");
        step(nop(), "ldm_in_mem");
        step(ins(1, 0, 9, 1, 0, 1, 1), "ldw_lw");
        step(ins(9, 0, 12, 1, 0, 1, 0), "ldw_stall");
        step(ins(9, 0, 12, 1, 0, 1, 0), "ldw_reissue");
        step(nop(), "ldw_in_wb");

        // branch taken in the same cycle as load-use
        step(ins(2, 0, 5, 1, 0, 1, 1), "br_lw");
        s = ins(5, 1, 6, 1, 1, 1, 0); s.br = 1;
        step(s, "br_lu");
        step(nop(), "br_after");

        // memory wait during the load-use stall
        step(ins(2, 0, 5, 1, 0, 1, 1), "mw_lw");
        step(ins(5, 1, 6, 1, 1, 1, 0), "mw_stall");
        s = ins(5, 1, 6, 1, 1, 1, 0); s.mr = 0;
        for (int i = 0; i < 3; i++) step(s, "mw_wait");
        step(ins(5, 1, 6, 1, 1, 1, 0), "mw_resume");
        step(nop(), "mw_fwd");
        step(nop(), "mw_drain");

        // memory wait before the stall can be taken, then resume
        step(ins(2, 0, 5, 1, 0, 1, 1), "mw2_lw");
        s = ins(5, 1, 6, 1, 1, 1, 0); s.mr = 0;
        step(s, "mw2_wait");
        step(ins(5, 1, 6, 1, 1, 1, 0), "mw2_stall");
        step(ins(5, 1, 6, 1, 1, 1, 0), "mw2_reissue");

        // reset in the middle of a wait
        step(ins(2, 0, 5, 1, 0, 1, 1), "rw_lw");
        step(ins(5, 1, 6, 1, 1, 1, 0), "rw_stall");
        s = ins(5, 1, 6, 1, 1, 1, 0); s.mr = 0;
        step(s, "rw_wait");
        s.rst = 1;
        step(s, "rw_reset");
        step(ins(5, 1, 6, 1, 1, 1, 0), "rw_release");
        step(nop(), "rw_after");

        for (int i = 0; i < 600; i++) begin
            s.rst   = ($urandom % 60) == 0;
            s.valid = ($urandom % 6) != 0;
            s.rs1   = 5'($urandom_range(0, 4));
            s.rs2   = 5'($urandom_range(0, 4));
            s.rd    = 5'($urandom_range(0, 4));
            s.u1    = ($urandom % 4) != 0;
            s.u2    = ($urandom % 4) != 0;
            s.wen   = ($urandom % 5) != 0;
            s.load  = ($urandom % 3) == 0;
            s.br    = ($urandom % 10) == 0;
            s.mr    = ($urandom % 5) != 0;
            step(s, "rand");
        end

        @(negedge clk);
        #1;
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port id_valid, input, 1, decode slot holds a real instruction.
REQ-004 SHALL have ports id_rs1_addr/id_rs2_addr/id_rd_addr, input, 5 each, decoded register addresses. The decoder already zeroes rs1 for LUI.
REQ-005 SHALL have ports id_uses_rs1/id_uses_rs2/id_rd_wen/id_is_load, input, 1 each, decode attributes.
REQ-006 SHALL have port ex_br_taken, input, 1, branch/jump in EX resolved taken.
REQ-007 SHALL have port mem_ready, input, 1, data memory ready; low freezes the pipe.
REQ-008 SHALL have ports pc_en/if_id_en, output, 1 each, PC and IF/ID register enables.
REQ-009 SHALL have ports if_id_flush/id_ex_flush, output, 1 each, insert bubble into IF/ID and ID/EX.
REQ-010 SHALL have ports fwd_a_sel/fwd_b_sel, output, 2 each: 00 regfile, 01 EX/MEM result, 10 MEM/WB result, 11 unused.
REQ-011 SHALL have port stall_cnt, output, 32, count of load-use stall cycles.

Function
REQ-012 SHALL keep three stage records: EX, MEM, WB. Each record is {valid, rs1, rs2, rd, wen, load}.
REQ-013 SHALL, when mem_ready=1, shift the records each cycle: ID->EX, EX->MEM, MEM->WB. ID->EX loads an invalid record when id_ex_flush=1 or id_valid=0.
REQ-014 SHALL, when mem_ready=0, hold all records, the FSM state and stall_cnt.
REQ-015 SHALL, when mem_ready=0, drive pc_en=0, if_id_en=0 and both flushes 0.
REQ-016 SHALL treat a hazard or forward match as "record valid & wen & rd!=0 & rd==source address". x0 never matches.
REQ-017 SHALL detect load-use when all of the following hold:
- id_valid=1;
- the EX record has load=1;
- (id_uses_rs1 & match rs1) | (id_uses_rs2 & match rs2).
REQ-018 SHALL implement FSM states RUN, LU_STALL and MEM_WAIT.
REQ-019 SHALL make these FSM transitions:
- RUN -> LU_STALL on load-use with mem_ready=1 and ex_br_taken=0.
- LU_STALL -> RUN after exactly one cycle.
- Any state -> MEM_WAIT when mem_ready=0.
- MEM_WAIT -> the state it left when mem_ready=1.
REQ-020 SHALL drive the load-use stall outputs combinationally in the detecting cycle: pc_en=0, if_id_en=0, id_ex_flush=1, stall_cnt+1. Stall length is one cycle and the dependent instruction then receives fwd=10.
REQ-021 SHALL, when ex_br_taken=1 and mem_ready=1, drive if_id_flush=1, id_ex_flush=1 and pc_en=1. Branch taken overrides a simultaneous load-use, and no stall is counted.
REQ-022 SHALL compute fwd_a_sel from the EX record rs1 and fwd_b_sel from the EX record rs2. MEM match gives 01, else WB match gives 10, else 00. MEM has priority when MEM and WB both match.
REQ-023 SHALL drive fwd 01 only when the MEM record has load=0; a load in MEM is never forwarded from EX/MEM.
REQ-024 SHALL let stall_cnt wrap from 0xFFFFFFFF to 0.
REQ-025 SHALL otherwise drive pc_en=1, if_id_en=1 and both flushes 0. Forward outputs are combinational, with zero-cycle latency.

Reset
REQ-026 SHALL, on a clock edge with rst=1, clear all records to invalid, set the FSM to RUN and set stall_cnt=0.
REQ-027 SHALL, while rst=1, drive pc_en=0, if_id_en=0, flushes 0 and fwd 00.
REQ-028 SHALL, on the first cycle after reset, drive pc_en=1, if_id_en=1, flushes 0 and fwd 00.
REQ-029 SHALL let rst asserted mid-stall or mid-MEM_WAIT abandon that stall or wait; no residual stall remains after release.

Structure
REQ-030 SHALL place stage_rec_t, the fwd_sel_t enum (FWD_RF/FWD_MEM/FWD_WB), the hc_state_t enum and the 5-bit REG_X0 constant in the shared riscv_pkg.
REQ-031 SHALL instantiate one sub-module, hazard_match, three times for the EX, MEM and WB comparisons. It takes a record and a source address and outputs the match bit.

Verification
REQ-032 SHALL cover load-use: lw x5 in EX, add x6,x5,x1 in ID -> 1 stall cycle (pc_en=0, id_ex_flush=1), stall_cnt=1, then fwd_a_sel=10.
REQ-033 SHALL cover EX/MEM forwarding: add x3 then sub x4,x3,x3 back-to-back -> fwd_a_sel=fwd_b_sel=01, no stall.
REQ-034 SHALL cover the x0 case: writer rd=x0 followed by a reader of x0 -> fwd 00, no stall. It SHALL also cover LUI x7: rs1=0, so no hazard on rs1.
REQ-035 SHALL cover priority: x9 written in MEM and WB -> fwd 01. It SHALL also cover a load in MEM -> 10 only once that load reaches WB.
REQ-036 SHALL cover branch vs load-use in the same cycle: ex_br_taken=1 -> both flushes=1, pc_en=1, stall_cnt unchanged.
REQ-037 SHALL cover memory wait: mem_ready=0 for 3 cycles during LU_STALL -> all enables 0 and records frozen, then resume with 1 stall total. It SHALL also cover rst mid-wait -> RUN with invalid records.
